// File: rtl/on_chip_fsm_pio_pkg.sv
// Shared constants for the PIO block: Avalon-MM word addresses and the
// edge-class encoding used by the capture logic.
package on_chip_fsm_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

endpackage

// File: rtl/on_chip_fsm_pio_edge_sync.sv
// Two-flop input synchroniser plus history flop; flags the selected edge
// class per bit by comparing the synchronised value with its history.
module on_chip_fsm_pio_edge_sync
  import on_chip_fsm_pio_pkg::*;
#(
  parameter int         DATA_WIDTH = 16,
  parameter edge_type_e EDGE_TYPE  = EDGE_RISING
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_in_port,
  output logic [DATA_WIDTH-1:0] o_sync2,
  output logic [DATA_WIDTH-1:0] o_edge
);

  logic [DATA_WIDTH-1:0] r_sync1;
  logic [DATA_WIDTH-1:0] r_sync2;
  logic [DATA_WIDTH-1:0] r_prev;
  logic [DATA_WIDTH-1:0] w_edge;

  // All three stages clear together so sync2 == prev right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= i_in_port;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  w_edge = r_sync2 & ~r_prev;
      EDGE_FALLING: w_edge = ~r_sync2 & r_prev;
      EDGE_ANY:     w_edge = r_sync2 ^ r_prev;
      default:      w_edge = '0;
    endcase
  end

  assign o_sync2 = r_sync2;
  assign o_edge  = w_edge;

endmodule

// File: rtl/on_chip_fsm_pio_gen2.sv
// Avalon-MM parallel I/O port: output data with set/clear aliases,
// direction register, per-bit edge capture and a masked level interrupt.
module on_chip_fsm_pio_gen2
  import on_chip_fsm_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter edge_type_e            EDGE_TYPE   = EDGE_RISING,
  parameter bit                    IRQ_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_oe,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] r_data_out;
  logic [DATA_WIDTH-1:0] r_dir;
  logic [DATA_WIDTH-1:0] r_irqmask;
  logic [DATA_WIDTH-1:0] r_edgecap;
  logic                  r_irq;
  logic [31:0]           r_readdata;

  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_sync2;
  logic [DATA_WIDTH-1:0] w_edge;
  logic [DATA_WIDTH-1:0] w_data_out_nxt;
  logic [DATA_WIDTH-1:0] w_edgecap_clr;
  logic [31:0]           w_rd;
  logic                  w_unused_wdata;

  on_chip_fsm_pio_edge_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_edge_sync (
    .clk       (clk),
    .reset     (reset),
    .i_in_port (in_port),
    .o_sync2   (w_sync2),
    .o_edge    (w_edge)
  );

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[DATA_WIDTH-1:0];
  assign w_unused_wdata = ^writedata;
  assign w_edgecap_clr  = (w_wr && address == ADDR_EDGECAP) ? w_wdata : '0;

  always_comb begin
    w_data_out_nxt = r_data_out;
    if (w_wr) begin
      case (address)
        ADDR_DATA:   w_data_out_nxt = w_wdata;
        ADDR_OUTSET: w_data_out_nxt = r_data_out | w_wdata;
        ADDR_OUTCLR: w_data_out_nxt = r_data_out & ~w_wdata;
        default:     w_data_out_nxt = r_data_out;
      endcase
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_DATA:    w_rd[DATA_WIDTH-1:0] = w_sync2;
      ADDR_DIR:     w_rd[DATA_WIDTH-1:0] = r_dir;
      ADDR_IRQMASK: w_rd[DATA_WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: w_rd[DATA_WIDTH-1:0] = r_edgecap;
      default:      w_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= RESET_VALUE;
      r_dir      <= '0;
      r_irqmask  <= '0;
      r_edgecap  <= '0;
      r_irq      <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_data_out <= w_data_out_nxt;
      if (w_wr && address == ADDR_DIR)     r_dir     <= w_wdata;
      if (w_wr && address == ADDR_IRQMASK) r_irqmask <= w_wdata;
      // A fresh edge overrides a simultaneous write-1-to-clear of the same bit.
      r_edgecap  <= (r_edgecap & ~w_edgecap_clr) | w_edge;
      r_irq      <= IRQ_EN ? |(r_edgecap & r_irqmask) : 1'b0;
      r_readdata <= w_rd;
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_data_out;
  assign out_oe   = r_dir;
  assign irq      = r_irq;

endmodule

// File: tb/tb_on_chip_fsm_pio_gen2.sv
// Directed bench for the PIO block: a RISING/IRQ-enabled instance and an
// ANY/IRQ-disabled instance share one bus and reset.
module tb_on_chip_fsm_pio_gen2;
  import on_chip_fsm_pio_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] in_port;
  logic [15:0] out_port;
  logic [15:0] out_oe;
  logic        irq;
  logic [31:0] readdata_b;
  logic [15:0] in_port_b;
  logic [15:0] out_port_b;
  logic [15:0] out_oe_b;
  logic        irq_b;

  int n_total = 0;
  int n_pass  = 0;

  on_chip_fsm_pio_gen2 #(
    .DATA_WIDTH  (16),
    .RESET_VALUE (16'h00C3),
    .EDGE_TYPE   (EDGE_RISING),
    .IRQ_EN      (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .out_oe     (out_oe),
    .irq        (irq)
  );

  on_chip_fsm_pio_gen2 #(
    .DATA_WIDTH  (16),
    .RESET_VALUE (16'h0000),
    .EDGE_TYPE   (EDGE_ANY),
    .IRQ_EN      (1'b0)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata_b),
    .in_port    (in_port_b),
    .out_port   (out_port_b),
    .out_oe     (out_oe_b),
    .irq        (irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a;
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 16'h0000;
    in_port_b  = 16'h0000;
    tick(3);
    reset = 1'b0;

    // reset state
    check("rst_readdata", readdata, 32'h0);
    check("rst_out_port", {16'h0, out_port}, 32'h00C3);
    check("rst_out_oe",   {16'h0, out_oe}, 32'h0);
    check("rst_irq",      {31'h0, irq}, 32'h0);
    check("rst_out_port_b", {16'h0, out_port_b}, 32'h0);

    // DATA write and synchronised readback latency
    in_port = 16'hA5A5;
    wr(ADDR_DATA, 32'h0000_1234);
    check("data_out_port", {16'h0, out_port}, 32'h1234);
    address = ADDR_DATA;
    tick();
    check("data_rd_early", readdata, 32'h0);
    tick();
    check("data_rd_a5a5", readdata, 32'h0000_A5A5);

    in_port = 16'h0000;
    tick(3);
    wr(ADDR_EDGECAP, 32'h0000_FFFF);
    rd(ADDR_EDGECAP);
    check("ecap_cleared", readdata, 32'h0);

    // OUTSET / OUTCLR, DIR, reserved addresses
    wr(ADDR_DATA, 32'h0000_00F0);
    wr(ADDR_OUTSET, 32'h0000_000F);
    check("outset", {16'h0, out_port}, 32'h00FF);
    wr(ADDR_OUTCLR, 32'h0000_0030);
    check("outclr", {16'h0, out_port}, 32'h00CF);
    wr(ADDR_DIR, 32'h0000_00FF);
    check("dir_oe", {16'h0, out_oe}, 32'h00FF);
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'h0000_0000);
    check("rsvd_out_port", {16'h0, out_port}, 32'h00CF);
    rd(ADDR_DIR);
    check("rsvd_dir", readdata, 32'h0000_00FF);
    rd(ADDR_OUTSET);
    check("rd_addr4", readdata, 32'h0);

    // rising edge -> EDGECAP -> irq -> W1C
    wr(ADDR_IRQMASK, 32'h0000_0001);
    address = ADDR_EDGECAP;
    in_port = 16'h0001;
    tick(3);
    check("irq_lag", {31'h0, irq}, 32'h0);
    check("ecap_rd_lag", readdata, 32'h0);
    tick();
    check("ecap_set", readdata, 32'h0000_0001);
    check("irq_set", {31'h0, irq}, 32'h1);
    wr(ADDR_EDGECAP, 32'h0000_0001);
    check("irq_hold_w1c", {31'h0, irq}, 32'h1);
    tick();
    check("irq_clr", {31'h0, irq}, 32'h0);
    check("ecap_w1c", readdata, 32'h0);

    // edge coinciding with W1C: bit0 survives, bit2 clears
    in_port = 16'h0000;
    tick(3);
    in_port = 16'h0005;
    tick(3);
    in_port = 16'h0000;
    tick(3);
    in_port = 16'h0001;
    tick(2);
    wr(ADDR_EDGECAP, 32'h0000_0005);
    rd(ADDR_EDGECAP);
    check("w1c_race_ecap", readdata, 32'h0000_0001);
    check("w1c_race_irq", {31'h0, irq}, 32'h1);

    // reset mid-operation with DIR=all ones and EDGECAP=0x0005
    in_port = 16'h0005;
    tick(3);
    wr(ADDR_DIR, 32'hFFFF_FFFF);
    check("dir_full_oe", {16'h0, out_oe}, 32'hFFFF);
    rd(ADDR_DIR);
    check("dir_rd_zext", readdata, 32'h0000_FFFF);
    rd(ADDR_EDGECAP);
    check("pre_rst_ecap", readdata, 32'h0000_0005);
    reset      = 1'b1;
    address    = ADDR_DATA;
    writedata  = 32'h0000_FFFF;
    chipselect = 1'b1;
    write_n    = 1'b0;
    in_port    = 16'h0007;
    tick();
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    check("mid_rst_oe", {16'h0, out_oe}, 32'h0);
    check("mid_rst_out_port", {16'h0, out_port}, 32'h00C3);
    check("mid_rst_readdata", readdata, 32'h0);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    rd(ADDR_EDGECAP);
    check("mid_rst_ecap", readdata, 32'h0);

    // ANY-edge instance with irq disabled
    wr(ADDR_IRQMASK, 32'h0000_FFFF);
    in_port_b = 16'h0003;
    tick(3);
    in_port_b = 16'h0001;
    tick(3);
    rd(ADDR_EDGECAP);
    check("any_ecap", readdata_b, 32'h0000_0003);
    check("any_irq_off", {31'h0, irq_b}, 32'h0);
    check("main_irq_post_rst", {31'h0, irq}, 32'h1);
    rd(ADDR_DATA);
    check("any_data_rd", readdata_b, 32'h0000_0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
